// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//
// Read sequencer in front of a read-only BRAM port. On start it walks len
// consecutive addresses from base (modulo 2**ADDR), issuing at most one read
// per cycle. It absorbs the 1-cycle BRAM read latency and presents the words
// as a valid/ready stream with the final beat marked by out_last.
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       synchronous, active-high reset
//   start      in   1       begin a burst (sampled only when idle)
//   base       in   ADDR    first address of the burst, sampled with start
//   len        in   ADDR+1  number of words 0..2**ADDR, sampled with start
//   busy       out  1       high from accepted start through the done pulse
//   done       out  1       one-cycle pulse at burst completion
//   mem_addr   out  ADDR    registered BRAM read address
//   mem_dout   in   DATA    BRAM read data, valid 1 cycle after mem_addr sampled
//   out_valid  out  1       output word available
//   out_ready  in   1       consumer accepts the current word
//   out_data   out  DATA    output word
//   out_last   out  1       final beat of the burst, qualified by out_valid
// -----------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR-1:0] base,
    input  logic [ADDR:0]   len,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] mem_addr,
    input  logic [DATA-1:0] mem_dout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic            out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic            last;
        logic [DATA-1:0] data;
    } entry_t;

    localparam logic [ADDR:0] ONE_WORD = {{ADDR{1'b0}}, 1'b1};

    state_t        state;
    state_t        state_next;

    logic [ADDR:0] remain;         // reads still to be issued in this burst
    logic          inflight;       // a read was issued last cycle; mem_dout holds it now
    logic          inflight_last;  // ...and that read is the final word of the burst

    entry_t        fifo_q [2];     // fifo_q[0] is the head and drives the outputs
    logic [1:0]    fifo_occ;

    logic          accept;
    logic          pop;
    logic          push;
    logic          issue;
    logic          last_issue;
    logic [2:0]    credit_used;
    logic [2:0]    credit_limit;
    entry_t        push_entry;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                // A zero-length burst never leaves IDLE; it only pulses done.
                if (accept && (len != '0)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue && last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs and handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        // The done cycle is still part of the burst, so a start that lands on
        // it is treated as arriving while busy and is dropped.
        accept       = (state == IDLE) && !done && start;
        busy         = (state != IDLE) || done;
        pop          = out_valid && out_ready;
        push         = inflight;
        last_issue   = (remain == ONE_WORD);

        // Words already committed to the FIFO (queued plus the one on
        // mem_dout, minus the one leaving now) must leave room for the read
        // issued this cycle, which lands in the FIFO next cycle.
        credit_used  = {1'b0, fifo_occ} + {2'b00, inflight};
        credit_limit = 3'd2 + {2'b00, pop};
        issue        = (state == ISSUE) && (credit_used < credit_limit);

        push_entry   = '{last: inflight_last, data: mem_dout};
    end

    // -------------------------------------------------------------------------
    // Address generator, read tracking, done pulse
    // -------------------------------------------------------------------------
    // mem_addr always presents the next address to read; an issue is a cycle
    // in which the BRAM's sample of it is consumed, after which it advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr      <= '0;
            remain        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= (accept && (len == '0)) ||
                             ((state == DRAIN) && pop && out_last);
            inflight      <= issue;
            inflight_last <= issue && last_issue;

            if (accept) begin
                mem_addr <= base;
                remain   <= len;
            end else if (issue) begin
                // Wraps naturally modulo 2**ADDR.
                mem_addr <= mem_addr + 1'b1;
                remain   <= remain - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // 2-entry output FIFO with registered outputs
    // -------------------------------------------------------------------------
    // The read credit above guarantees a push never meets a full FIFO without
    // a simultaneous pop, and a pop only happens when the FIFO is non-empty.
    // NOTE: the storage is reset along with the control because the head entry
    // drives out_data/out_last directly and those must read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_occ  <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (fifo_occ == 2'd0) begin
                        fifo_q[0] <= push_entry;
                    end else begin
                        fifo_q[1] <= push_entry;
                    end
                    fifo_occ <= fifo_occ + 1'b1;
                end
                2'b01: begin
                    fifo_q[0] <= fifo_q[1];
                    fifo_occ  <= fifo_occ - 1'b1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes behind
                    // whatever remains after the head leaves.
                    if (fifo_occ == 2'd1) begin
                        fifo_q[0] <= push_entry;
                    end else begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (fifo_occ != 2'd0);
    assign out_data  = fifo_q[0].data;
    // Stale head contents after the FIFO empties must not look like a last beat.
    assign out_last  = fifo_q[0].last && out_valid;

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Self-checking bench for bram_stream_reader. A behavioural BRAM answers reads
// one cycle late. Every accepted burst pushes its expected beats (memory
// contents at base..base+len-1 mod 1024, last flag on the final one) into a
// queue; an independent monitor compares the presented word against the queue
// head every cycle out_valid is high and pops on each handshake.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int DATA  = 72;
    localparam int ADDR  = 10;
    localparam int DEPTH = 1 << ADDR;

    typedef struct packed {
        logic            last;
        logic [DATA-1:0] data;
    } beat_t;

    logic            clk;
    logic            reset;
    logic            start;
    logic [ADDR-1:0] base;
    logic [ADDR:0]   len;
    logic            busy;
    logic            done;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_dout;
    logic            out_valid;
    logic            out_ready;
    logic [DATA-1:0] out_data;
    logic            out_last;

    logic [DATA-1:0] mem [DEPTH];
    beat_t           exp_q [$];
    beat_t           popped;

    int n_tests;
    int n_fail;
    int done_seen;
    int bursts_expected;
    int ready_mode;

    bram_stream_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only BRAM port: address sampled on the edge, data valid next cycle.
    always @(posedge clk) begin
        mem_dout <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [DATA-1:0] got,
                         input logic [DATA-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: the presented word must always equal the oldest expected beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_seen++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {71'd0, out_valid}, '0);
                end else begin
                    check("beat_data", out_data, exp_q[0].data);
                    check("beat_last", {71'd0, out_last}, {71'd0, exp_q[0].last});
                    if (out_ready) popped = exp_q.pop_front();
                end
            end
        end
    end

    // Consumer backpressure pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert start for one cycle and record what the burst must produce.
    task automatic start_burst(input logic [ADDR-1:0] b, input logic [ADDR:0] l);
        logic [ADDR-1:0] a;
        a = b;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back('{last: (i == int'(l) - 1), data: mem[a]});
            a = a + 1'b1;
        end
        bursts_expected++;
        start = 1'b1;
        base  = b;
        len   = l;
        tick();
        start = 1'b0;
        // Post-acceptance changes must be ignored.
        base  = ADDR'($urandom);
        len   = (ADDR + 1)'($urandom);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done_seen < bursts_expected && t < 6000) begin
            tick();
            t++;
        end
        check(name, DATA'(done_seen), DATA'(bursts_expected));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      {71'd0, busy},      '0);
        check({tag, "_done"},      {71'd0, done},      '0);
        check({tag, "_mem_addr"},  DATA'(mem_addr),    '0);
        check({tag, "_out_valid"}, {71'd0, out_valid}, '0);
        check({tag, "_out_last"},  {71'd0, out_last},  '0);
        check({tag, "_out_data"},  out_data,           '0);
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        done_seen       = 0;
        bursts_expected = 0;
        ready_mode      = 0;
        reset           = 1'b1;
        start           = 1'b0;
        base            = '0;
        len             = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA'(i);

        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // 1: base=5 len=4, full throughput, exact latency and done timing.
        start_burst(10'd5, 11'd4);
        check("t1_addr_at_T1", DATA'(mem_addr), DATA'(5));
        check("t1_busy", {71'd0, busy}, {71'd0, 1'b1});
        check("t1_valid_T1", {71'd0, out_valid}, '0);
        tick();
        check("t1_valid_T2", {71'd0, out_valid}, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_valid_beat", {71'd0, out_valid}, {71'd0, 1'b1});
            check("t1_last_beat", {71'd0, out_last}, {71'd0, (k == 3)});
            check("t1_no_early_done", {71'd0, done}, '0);
        end
        tick();
        check("t1_done", {71'd0, done}, {71'd0, 1'b1});
        check("t1_valid_after", {71'd0, out_valid}, '0);
        wait_done("t1_done_count");
        check("t1_done_once", {71'd0, done}, '0);

        // 2: wrap-around.
        start_burst(10'd1022, 11'd4);
        wait_done("t2_wrap_done");

        // 3: zero-length burst.
        start_burst(10'd7, 11'd0);
        check("t3_busy_T1", {71'd0, busy}, {71'd0, 1'b1});
        check("t3_done_T1", {71'd0, done}, {71'd0, 1'b1});
        tick();
        check("t3_busy_T2", {71'd0, busy}, '0);
        check("t3_done_T2", {71'd0, done}, '0);
        wait_done("t3_done_count");

        // 4: len=64 under random backpressure.
        ready_mode = 1;
        start_burst(10'd300, 11'd64);
        wait_done("t4_done");
        ready_mode = 2;
        start_burst(10'd990, 11'd64);
        wait_done("t4b_done");
        ready_mode = 0;

        // 5: a second start mid-burst is ignored.
        start_burst(10'd40, 11'd20);
        repeat (5) tick();
        start = 1'b1;
        base  = 10'd100;
        len   = 11'd7;
        tick();
        start = 1'b0;
        wait_done("t5_done");
        repeat (4) tick();
        check("t5_no_extra_done", DATA'(done_seen), DATA'(bursts_expected));

        // 6: reset three cycles into a burst, then a fresh short burst.
        ready_mode = 1;
        start_burst(10'd200, 11'd16);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        bursts_expected--;
        check_reset_values("t6_reset");
        reset = 1'b0;
        ready_mode = 0;
        repeat (4) tick();
        check("t6_no_done_after_abort", DATA'(done_seen), DATA'(bursts_expected));
        start_burst(10'd0, 11'd2);
        wait_done("t6_done");

        // Random data and bursts, including one full-memory sweep.
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom};
        ready_mode = 1;
        start_burst(10'd777, 11'd1024);
        wait_done("full_sweep_done");
        for (int n = 0; n < 14; n++) begin
            ready_mode = $urandom_range(0, 2);
            start_burst(ADDR'($urandom), (ADDR + 1)'($urandom_range(0, 40)));
            wait_done("rand_done");
        end

        repeat (5) tick();
        check("final_done_count", DATA'(done_seen), DATA'(bursts_expected));
        check("final_queue_empty", DATA'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
